// File: rtl/if_id_buffer.sv
// IF->ID pipeline boundary: two-entry elastic buffer (main + skid) with registered handshakes.
// Optional perf counters (stall_cnt, flush_cnt) are built only when IFID_PERF_EN is defined.
module if_id_buffer #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter logic [ILEN-1:0] NOP_INSN = 32'h0000_0013,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_if_valid,
  output logic             o_if_ready,
  input  logic [XLEN-1:0]  i_if_pc,
  input  logic [ILEN-1:0]  i_if_insn,
  input  logic             i_flush,
  output logic             o_id_valid,
  input  logic             i_id_ready,
  output logic [XLEN-1:0]  o_id_pc,
  output logic [ILEN-1:0]  o_id_insn,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e          r_state, w_state_d;
  logic [XLEN-1:0] r_main_pc, w_main_pc_d, r_skid_pc, w_skid_pc_d;
  logic [ILEN-1:0] r_main_insn, w_main_insn_d, r_skid_insn, w_skid_insn_d;

  always_comb begin
    w_state_d     = r_state;
    w_main_pc_d   = r_main_pc;
    w_main_insn_d = r_main_insn;
    w_skid_pc_d   = r_skid_pc;
    w_skid_insn_d = r_skid_insn;
    if (i_flush) begin
      w_state_d     = StEmpty;
      w_main_pc_d   = '0;
      w_main_insn_d = NOP_INSN;
      w_skid_pc_d   = '0;
      w_skid_insn_d = NOP_INSN;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (i_if_valid) begin
            w_state_d     = StFull;
            w_main_pc_d   = i_if_pc;
            w_main_insn_d = i_if_insn;
          end
        end
        StFull: begin
          if (i_id_ready && i_if_valid) begin
            w_main_pc_d   = i_if_pc;
            w_main_insn_d = i_if_insn;
          end else if (i_id_ready) begin
            // Main register doubles as the output, so park the bubble in it.
            w_state_d     = StEmpty;
            w_main_pc_d   = '0;
            w_main_insn_d = NOP_INSN;
          end else if (i_if_valid) begin
            w_state_d     = StSkid;
            w_skid_pc_d   = i_if_pc;
            w_skid_insn_d = i_if_insn;
          end
        end
        StSkid: begin
          if (i_id_ready) begin
            w_state_d     = StFull;
            w_main_pc_d   = r_skid_pc;
            w_main_insn_d = r_skid_insn;
            w_skid_pc_d   = '0;
            w_skid_insn_d = NOP_INSN;
          end
        end
        default: begin
          w_state_d     = StEmpty;
          w_main_pc_d   = '0;
          w_main_insn_d = NOP_INSN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StEmpty;
      r_main_pc   <= '0;
      r_main_insn <= NOP_INSN;
      r_skid_pc   <= '0;
      r_skid_insn <= NOP_INSN;
    end else begin
      r_state     <= w_state_d;
      r_main_pc   <= w_main_pc_d;
      r_main_insn <= w_main_insn_d;
      r_skid_pc   <= w_skid_pc_d;
      r_skid_insn <= w_skid_insn_d;
    end
  end

  // Handshake outputs decode the state flop only, never id_ready.
  assign o_if_ready = (r_state != StSkid);
  assign o_id_valid = (r_state != StEmpty);
  assign o_id_pc    = r_main_pc;
  assign o_id_insn  = r_main_insn;

`ifdef IFID_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_stall_inc, w_flush_inc;

  assign w_stall_inc = o_id_valid & ~i_id_ready & ~i_flush;
  assign w_flush_inc = o_id_valid & i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: accepted inputs are queued, a monitor checks the ID side.
module tb_if_id_buffer;

  localparam logic [31:0] Nop = 32'h0000_0013;
`ifdef IFID_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, id_ready;
  logic        if_ready, id_valid;
  logic [31:0] if_pc, if_insn, id_pc, id_insn, stall_cnt, flush_cnt;

  logic [63:0] sb_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  if_id_buffer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_if_valid (if_valid),
    .o_if_ready (if_ready),
    .i_if_pc    (if_pc),
    .i_if_insn  (if_insn),
    .i_flush    (flush),
    .o_id_valid (id_valid),
    .i_id_ready (id_ready),
    .o_id_pc    (id_pc),
    .o_id_insn  (id_insn),
    .o_stall_cnt(stall_cnt),
    .o_flush_cnt(flush_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Expected response for every accepted fetch; flush and reset empty the scoreboard.
  always @(posedge clk) begin
    if (rst || flush) sb_q.delete();
    else if (if_valid && if_ready) sb_q.push_back({if_pc, if_insn});
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (id_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", {32'h0, id_pc}, 64'hffff_ffff_ffff_ffff);
        end else begin
          chk("head_entry", {id_pc, id_insn}, sb_q[0]);
          if (id_ready && !flush) void'(sb_q.pop_front());
        end
      end else begin
        chk("empty_bubble", {id_pc, id_insn}, {32'h0, Nop});
        chk("empty_sb", 64'(sb_q.size()), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_insn  = 32'h0010_0093 + pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
    drive(1'b0, 32'h0);
    tick(); tick();
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);
    chk("rst_id_insn", 64'(id_insn), 64'(Nop));
    chk("rst_id_pc", 64'(id_pc), 64'd0);
    rst = 1'b0;

    // Streaming with decode always ready
    id_ready = 1'b1;
    drive(1'b1, 32'h0); tick();
    chk("stream_latency", {32'(id_valid), id_pc}, {32'd1, 32'h0});
    drive(1'b1, 32'h4); tick();
    chk("stream_if_ready", 64'(if_ready), 64'd1);
    drive(1'b1, 32'h8); tick();
    chk("stream_if_ready2", 64'(if_ready), 64'd1);
    drive(1'b0, 32'h0); tick(); tick();

    // Backpressure into the skid slot
    id_ready = 1'b0;
    drive(1'b1, 32'h10); tick();
    drive(1'b1, 32'h14); tick();
    chk("bp_if_ready", 64'(if_ready), 64'd0);
    chk("bp_hold_pc", 64'(id_pc), 64'h10);
    drive(1'b1, 32'h18); tick();
    chk("bp_hold_pc2", 64'(id_pc), 64'h10);
    drive(1'b0, 32'h0); id_ready = 1'b1; tick();
    chk("bp_skid_pc", {32'(if_ready), id_pc}, {32'd1, 32'h14});
    tick();
    chk("bp_drained", 64'(id_valid), 64'd0);

    // Flush in SKID with a same-cycle input
    id_ready = 1'b0;
    drive(1'b1, 32'h20); tick();
    drive(1'b1, 32'h24); tick();
    flush = 1'b1; drive(1'b1, 32'h28); tick();
    flush = 1'b0; drive(1'b1, 32'h80); id_ready = 1'b1;
    chk("flush_valid", 64'(id_valid), 64'd0);
    chk("flush_insn", {id_pc, id_insn}, {32'h0, Nop});
    chk("flush_cnt1", 64'(flush_cnt), Perf ? 64'd1 : 64'd0);
    tick();
    chk("post_flush_pc", {32'(id_valid), id_pc}, {32'd1, 32'h80});
    drive(1'b0, 32'h0); tick();

    // Flush in FULL: if_ready=1 input still dropped
    id_ready = 1'b0;
    drive(1'b1, 32'h40); tick();
    flush = 1'b1; drive(1'b1, 32'h44); tick();
    flush = 1'b0; drive(1'b0, 32'h0);
    chk("flush_full_valid", 64'(id_valid), 64'd0);
    chk("flush_cnt2", 64'(flush_cnt), Perf ? 64'd2 : 64'd0);
    tick();
    chk("flush_dropped", 64'(id_valid), 64'd0);

    // Flush while empty does not count
    flush = 1'b1; drive(1'b1, 32'h30); tick();
    flush = 1'b0; drive(1'b0, 32'h0);
    chk("flush_empty_cnt", 64'(flush_cnt), Perf ? 64'd2 : 64'd0);
    tick();
    chk("flush_empty_valid", 64'(id_valid), 64'd0);

    // Stall counting from a clean reset
    rst = 1'b1; sb_q.delete(); tick(); rst = 1'b0;
    chk("rst2_stall", 64'(stall_cnt), 64'd0);
    id_ready = 1'b0;
    drive(1'b1, 32'h100); tick();
    drive(1'b0, 32'h0);
    repeat (5) tick();
    chk("stall_cnt5", 64'(stall_cnt), Perf ? 64'd5 : 64'd0);

    // Async reset in SKID, mid-cycle
    drive(1'b1, 32'h104); tick();
    drive(1'b0, 32'h0);
    chk("pre_rst_skid", 64'(if_ready), 64'd0);
    #2;
    rst = 1'b1; sb_q.delete();
    #1;
    chk("arst_id_valid", 64'(id_valid), 64'd0);
    chk("arst_if_ready", 64'(if_ready), 64'd1);
    chk("arst_out", {id_pc, id_insn}, {32'h0, Nop});
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    tick(); rst = 1'b0;
    id_ready = 1'b1;
    tick(); tick();
    chk("no_stale", 64'(id_valid), 64'd0);
    drive(1'b1, 32'h200); tick();
    chk("post_rst_pc", {32'(id_valid), id_pc}, {32'd1, 32'h200});
    drive(1'b0, 32'h0); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
